fp_argmax_ctrl: RTL and testbench
=================================

Name: fp_argmax_ctrl

Overview:
Sequencer that streams a block of single-precision floats through the shared combinational FP comparator (comparison-only configuration) and returns the maximum value and the index of its position in the block. It owns the comparator operands and opcode. It feeds each new sample against the running best and updates the best register from the comparator verdict. It sits between a sample producer (valid/ready stream) and the consumer that needs the argmax, e.g. a classifier output stage.

Parameters:
IDX_W, 4, width of element index; maximum block length is 2**IDX_W
CMP_OP, 3, opcode driven on cmp_n; selects "dataa > datab" in the comparator, with result[0]=1 when true

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a new block; sampled only in IDLE
count  in  IDX_W+1  number of elements in block (0..2**IDX_W); latched on accepted start
in_valid  in  1  sample present on in_data
in_ready  out  1  controller accepts sample this cycle
in_data  in  32  IEEE-754 single sample
cmp_dataa  out  32  comparator operand A (new sample)
cmp_datab  out  32  comparator operand B (running best)
cmp_n  out  4  comparator opcode, constant CMP_OP
cmp_result  in  32  comparator result, combinational from cmp_dataa/cmp_datab/cmp_n
busy  out  1  block in progress
done  out  1  one-cycle pulse: max_data/max_index valid
empty  out  1  last block had count=0
max_data  out  32  largest sample of last block
max_index  out  IDX_W  0-based position of max_data in last block

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset=0 at a clk edge), from any state including mid-block:
  - state<=IDLE.
  - busy, done, empty, in_ready all 0.
  - max_data, max_index and the best register cleared to 0.
  - Element counter cleared to 0.
- Combinational outputs:
  - cmp_dataa = in_data.
  - cmp_datab = best register.
  - cmp_n = CMP_OP at all times.
  - in_ready = 1 only in FIRST or RUN.
- A sample is accepted on a cycle with in_valid & in_ready.
- States:
  - IDLE: done=0, busy=0.
    - start=1 and count>0: latch count, clear element counter, empty<=0, go FIRST.
    - start=1 and count=0: go DONE with empty<=1, max_data<=0, max_index<=0.
    - Otherwise stay in IDLE.
  - FIRST: busy=1.
    - On accept, load best<=in_data and best_idx<=0 unconditionally (the comparator verdict is ignored), counter<=1.
    - If count=1, go DONE; else go RUN.
  - RUN: busy=1.
    - On accept, if cmp_result[0]=1, then best<=in_data and best_idx<=counter.
    - Counter increments on every accept.
    - When the accept brings the counter equal to count, go DONE.
    - No accept means hold all state; bubbles of any length are allowed.
  - DONE: single cycle.
    - done=1, busy=0, max_data=best, max_index=best_idx.
    - Unconditionally go IDLE next cycle.
- max_data, max_index and empty hold their values until the next block's DONE or a reset.
- Latency: done asserts the cycle after the last sample is accepted. A block of N back-to-back samples completes in N+2 cycles from start.
- Ties: comparison is strict greater, so the earliest occurrence of the maximum wins.
- NaN: the comparator returns false, so a NaN sample never replaces the best. A NaN loaded as the first element stays best unless the comparator reports a greater value. That behaviour is defined by the comparator.
- -0.0 vs +0.0: treated as equal, so the earlier one is kept.
- start asserted while busy or in DONE: ignored, not queued.
- start held high continuously: a new block begins on the cycle after DONE, i.e. in IDLE.
- count=2**IDX_W: the final best_idx is 2**IDX_W-1. The counter is IDX_W+1 bits wide and never wraps within a block.
- in_valid in IDLE/DONE: in_ready=0, so no accept and no state change.

Test Plan:
- Reset, then start with count=4 and back-to-back samples 1.0(3F800000), 2.0(40000000), 0.5(3F000000), -3.0(C0400000).
  - Required: done pulses on cycle 6 after start.
  - Required: max_data=40000000, max_index=1, empty=0.
- count=3 with samples 2.0, 2.0, 1.0.
  - Required: max_index=0 (tie keeps earliest).
- count=0 start.
  - Required: done on the next cycle, empty=1, max_data=0, max_index=0, in_ready never asserted.
- count=16 with ascending samples 1.0..16.0 and random in_valid gaps.
  - Required: max_index=15, max_data=41800000.
  - Required: cmp_n=3 throughout.
  - Required: no accept while in_valid=0.
- Mid-block reset after 2 of 4 samples, then a fresh start with count=2 and samples -1.0(BF800000), -2.0(C0000000).
  - Required: all outputs cleared at reset.
  - Required: second block gives max_data=BF800000, max_index=0.
- start pulsed during RUN, plus a NaN(7FC00000) as the second of 3 samples (1.0, NaN, 0.5).
  - Required: the extra start is ignored.
  - Required: max_data=3F800000, max_index=0, exactly one done pulse.

Source files
------------

// File: rtl/fp_argmax_ctrl.sv
// fp_argmax_ctrl
//   Streams a block of IEEE-754 single-precision samples against a shared
//   combinational comparator and reports the largest value and its 0-based
//   position in the block.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; count latched on an accepted start
//   FIRST | first sample is loaded as best without consulting comparator
//   RUN   | each accepted sample replaces best when it compares greater
//   DONE  | one-cycle done pulse; max_data/max_index/empty updated
//
// Ports
//   clk, reset               clock, synchronous active-low reset
//   start, count             begin block of count elements (0..2**IDX_W)
//   in_valid/in_ready/in_data  sample stream
//   cmp_dataa/cmp_datab/cmp_n  comparator operands (sample, best) and opcode
//   cmp_result               comparator verdict, bit 0 = dataa > datab
//   busy, done, empty        status
//   max_data, max_index      result of the last block
module fp_argmax_ctrl #(
    parameter int         IDX_W  = 4,
    parameter logic [3:0] CMP_OP = 4'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      cmp_dataa,
    output logic [31:0]      cmp_datab,
    output logic [3:0]       cmp_n,
    input  logic [31:0]      cmp_result,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [31:0]      max_data,
    output logic [IDX_W-1:0] max_index
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [31:0]      best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             empty_q, empty_d;
    logic [31:0]      max_data_q, max_data_d;
    logic [IDX_W-1:0] max_index_q, max_index_d;

    logic             accept;
    logic [IDX_W:0]   cnt_inc;
    logic             unused_cmp;

    assign in_ready  = (state_q == S_FIRST) || (state_q == S_RUN);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign cmp_dataa = in_data;
    assign cmp_datab = best_q;
    assign cmp_n     = CMP_OP;
    assign unused_cmp = ^cmp_result[31:1];

    assign busy      = busy_q;
    assign done      = done_q;
    assign empty     = empty_q;
    assign max_data  = max_data_q;
    assign max_index = max_index_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        empty_d     = empty_q;
        max_data_d  = max_data_q;
        max_index_d = max_index_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (count != '0) begin
                        count_d = count;
                        cnt_d   = '0;
                        empty_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_FIRST;
                    end else begin
                        empty_d     = 1'b1;
                        max_data_d  = '0;
                        max_index_d = '0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_FIRST: begin
                if (accept) begin
                    best_d     = in_data;
                    best_idx_d = '0;
                    cnt_d      = {{IDX_W{1'b0}}, 1'b1};
                    if (count_q == {{IDX_W{1'b0}}, 1'b1}) begin
                        max_data_d  = in_data;
                        max_index_d = '0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    // cnt_q is at most 2**IDX_W-1 here, so the low bits hold the index
                    if (cmp_result[0]) begin
                        best_d     = in_data;
                        best_idx_d = cnt_q[IDX_W-1:0];
                    end
                    if (cnt_inc == count_q) begin
                        max_data_d  = best_d;
                        max_index_d = best_idx_d;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b0;
            max_data_q  <= '0;
            max_index_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            empty_q     <= empty_d;
            max_data_q  <= max_data_d;
            max_index_q <= max_index_d;
        end
    end

endmodule

// File: tb/tb_fp_argmax_ctrl.sv
// Testbench for fp_argmax_ctrl: models the comparator, drives directed
// blocks and checks results through an expected-result queue.
module tb_fp_argmax_ctrl;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W:0]   count;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      cmp_dataa;
    logic [31:0]      cmp_datab;
    logic [3:0]       cmp_n;
    logic [31:0]      cmp_result;
    logic             busy;
    logic             done;
    logic             empty;
    logic [31:0]      max_data;
    logic [IDX_W-1:0] max_index;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    bit ready_watch = 1'b0;

    logic [31:0] samples[$];
    logic [36:0] sb_q[$];   // {max_data, max_index, empty}

    always #5 clk = ~clk;

    fp_argmax_ctrl #(.IDX_W(IDX_W), .CMP_OP(4'd3)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmp_dataa(cmp_dataa), .cmp_datab(cmp_datab), .cmp_n(cmp_n),
        .cmp_result(cmp_result), .busy(busy), .done(done), .empty(empty),
        .max_data(max_data), .max_index(max_index)
    );

    // Strict IEEE greater-than: NaN compares false, +0 == -0.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan) return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    assign cmp_result = {31'd0, (cmp_n == 4'd3) && fp_gt(cmp_dataa, cmp_datab)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmp_n_const", 32'(cmp_n), 32'd3);
            chk("cmp_dataa_is_in_data", cmp_dataa, in_data);
            if (!in_valid) chk("busy_not_done_on_gap", 32'(done && busy), 32'd0);
        end
        if (ready_watch) chk("in_ready_count0", 32'(in_ready), 32'd0);
    end

    task automatic run_block(input int n, input bit gaps, input bit pulse_start, input int exp_lat);
        logic [31:0]      eb;
        logic [IDX_W-1:0] ei;
        logic [36:0]      e;
        int k, cyc, budget;
        eb = 32'd0;
        ei = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || fp_gt(samples[i], eb)) begin
                eb = samples[i];
                ei = IDX_W'(i);
            end
        end
        sb_q.push_back({eb, ei, (n == 0)});

        start = 1'b1;
        count = (IDX_W+1)'(n);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        k = 0;
        budget = 0;
        while (k < n && budget < 600) begin
            in_data  = samples[k];
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start    = (pulse_start && k == 1) ? 1'b1 : 1'b0;
            if (in_valid && in_ready) k++;
            @(negedge clk);
            cyc++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_budget", 32'(k), 32'(n));
        chk("done_after_last_accept", 32'(done), 32'd1);
        while (!done && budget < 600) begin
            @(negedge clk);
            cyc++;
            budget++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (exp_lat >= 0) chk("done_latency", 32'(cyc), 32'(exp_lat));
        chk("busy_at_done", 32'(busy), 32'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("max_data", max_data, e[36:5]);
            chk("max_index", 32'(max_index), 32'(e[4:1]));
            chk("empty", 32'(empty), 32'(e[0]));
        end
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
        if (pulse_start) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_queued_start", 32'(busy | done), 32'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; in_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_empty", 32'(empty), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_max_data", max_data, 32'd0);
        chk("rst_max_index", 32'(max_index), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Block 1: four back-to-back samples, done on cycle 6
        samples = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000};
        run_block(4, 1'b0, 1'b0, 6);
        chk("b1_max_data_const", max_data, 32'h40000000);
        chk("b1_max_index_const", 32'(max_index), 32'd1);

        // Block 2: tie keeps earliest
        samples = '{32'h40000000, 32'h40000000, 32'h3F800000};
        run_block(3, 1'b0, 1'b0, 5);
        chk("b2_tie_index", 32'(max_index), 32'd0);

        // Block 3: empty block
        ready_watch = 1'b1;
        samples = {};
        run_block(0, 1'b0, 1'b0, 2);
        ready_watch = 1'b0;

        // Block 4: full-length ascending block with random gaps
        samples = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        run_block(16, 1'b1, 1'b0, -1);
        chk("b4_max_data_const", max_data, 32'h41800000);
        chk("b4_max_index_const", 32'(max_index), 32'd15);

        // Mid-block reset after two of four samples
        start = 1'b1; count = 5'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h41A00000;
        @(negedge clk);
        in_data = 32'h41B00000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_max_data", max_data, 32'd0);
        chk("mrst_max_index", 32'(max_index), 32'd0);
        chk("mrst_best", cmp_datab, 32'd0);
        @(negedge clk);
        samples = '{32'hBF800000, 32'hC0000000};
        run_block(2, 1'b0, 1'b0, 4);
        chk("b5_max_data_const", max_data, 32'hBF800000);
        chk("b5_max_index_const", 32'(max_index), 32'd0);

        // Block 6: start pulsed mid-block, NaN as second sample
        samples = '{32'h3F800000, 32'h7FC00000, 32'h3F000000};
        run_block(3, 1'b0, 1'b1, 5);
        chk("b6_max_data_const", max_data, 32'h3F800000);
        chk("b6_max_index_const", 32'(max_index), 32'd0);

        mon_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
